// File: rtl/dwconv_pkg.sv
// dwconv_pkg: shared depthwise-conv constants, bundle type and ReLU helper
package dwconv_pkg;
  localparam int DW_N_CNT = 32;
  localparam int DW_N_POS = 9;
  localparam int DW_N_LANE = 4;
  localparam int DW_DATA_W = 32;
  typedef struct packed {
    logic [$clog2(DW_N_CNT)-1:0] cnt;
    logic [$clog2(DW_N_POS)-1:0] pos;
    logic [DW_N_LANE-1:0][DW_DATA_W-1:0] lanes;
  } bundle_t;
  function automatic logic [DW_DATA_W-1:0] relu(input logic [DW_DATA_W-1:0] x, input logic en);
    return (en && x[DW_DATA_W-1]) ? '0 : x;
  endfunction
endpackage

// File: rtl/dwconv_bundle_fifo.sv
// dwconv_bundle_fifo: synchronous FIFO of bundles with registered occupancy
module dwconv_bundle_fifo
  import dwconv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_b,
  input  logic    push,
  input  logic    pop,
  input  bundle_t din,
  output bundle_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  bundle_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= din;
  always_comb begin
    dout  = mem_q[rp_q];
    full  = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
  end
endmodule

// File: rtl/dwconv_out_writer.sv
// dwconv_out_writer: ReLU at push, bundle FIFO, and serialisation of each
// bundle into four word writes to the output feature-map buffer.
module dwconv_out_writer
  import dwconv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int N_LANE     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_cnt,
  input  logic [3:0]        in_pos,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic              relu_en,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done
);
  localparam int LW = $clog2(N_LANE);
  bundle_t in_b, head;
  logic full, empty, push, pop, hs, done_d, done_q;
  logic [LW-1:0] lane_q, lane_d;
  dwconv_bundle_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_b(rst_b), .push(push), .pop(pop),
    .din(in_b), .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    in_b.cnt      = in_cnt;
    in_b.pos      = in_pos;
    in_b.lanes[0] = relu(in_data0, relu_en);
    in_b.lanes[1] = relu(in_data1, relu_en);
    in_b.lanes[2] = relu(in_data2, relu_en);
    in_b.lanes[3] = relu(in_data3, relu_en);
    in_ready = !full;
    push     = in_valid && !full;
    wr_valid = !empty;
    hs       = !empty && wr_ready;
    pop      = hs && lane_q == LW'(N_LANE - 1);
    lane_d   = hs ? lane_q + LW'(1) : lane_q;
    done_d   = pop && head.cnt == 5'(DW_N_CNT - 1) && head.pos == 4'(DW_N_POS - 1);
    wr_data  = empty ? '0 : head.lanes[lane_q];
    // cnt*36 as two shifts keeps the address path out of multipliers
    wr_addr  = empty ? '0 : (ADDR_W'(head.cnt) << 5) + (ADDR_W'(head.cnt) << 2)
                          + (ADDR_W'(head.pos) << 2) + ADDR_W'(lane_q);
    done     = done_q;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      lane_q <= '0;
      done_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_dwconv_out_writer.sv
// tb_dwconv_out_writer: directed self-checking bench for dwconv_out_writer
module tb_dwconv_out_writer;
  logic clk = 1'b0, rst_b = 1'b0, in_valid = 1'b0, relu_en = 1'b0, wr_ready = 1'b0;
  logic [4:0] in_cnt = '0;
  logic [3:0] in_pos = '0;
  logic [31:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic in_ready, wr_valid, done;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  int total = 0, bad = 0;

  dwconv_out_writer dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_cnt(in_cnt), .in_pos(in_pos), .in_data0(d0), .in_data1(d1),
    .in_data2(d2), .in_data3(d3), .relu_en(relu_en), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] val(input int c, input int p, input int l);
    return 32'(c * 1000 + p * 10 + l);
  endfunction

  task automatic drive(input int c, input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input logic [31:0] f, input logic r);
    in_cnt = 5'(c); in_pos = 4'(p);
    d0 = a; d1 = b; d2 = e; d3 = f;
    relu_en = r; in_valid = 1'b1;
  endtask

  task automatic drive_std(input int c, input int p);
    drive(c, p, val(c, p, 0), val(c, p, 1), val(c, p, 2), val(c, p, 3), 1'b0);
  endtask

  initial begin
    logic [31:0] sd [4];
    logic [31:0] rd [4];
    logic p;
    int k, idx, dones, settle;
    logic last1151;
    sd = '{32'd10, 32'hFFFFFFFB, 32'd7, 32'd0};
    rd = '{32'd10, 32'd0, 32'd7, 32'd0};
    #3;
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    #4 rst_b = 1'b1;
    step();
    // single bundle, no ReLU
    wr_ready = 1'b1;
    drive(2, 3, 32'd10, 32'hFFFFFFFB, 32'd7, 32'd0, 1'b0);
    chk("single_pre_valid", 32'(wr_valid), 32'd0);
    step();
    in_valid = 1'b0;
    for (int l = 0; l < 4; l++) begin
      chk("single_valid", 32'(wr_valid), 32'd1);
      chk("single_addr", 32'(wr_addr), 32'(84 + l));
      chk("single_data", wr_data, sd[l]);
      chk("single_done", 32'(done), 32'd0);
      step();
    end
    chk("single_idle", 32'(wr_valid), 32'd0);
    // same bundle with ReLU
    drive(2, 3, 32'd10, 32'hFFFFFFFB, 32'd7, 32'd0, 1'b1);
    step();
    in_valid = 1'b0; relu_en = 1'b0;
    for (int l = 0; l < 4; l++) begin
      chk("relu_addr", 32'(wr_addr), 32'(84 + l));
      chk("relu_data", wr_data, rd[l]);
      step();
    end
    chk("relu_idle", 32'(wr_valid), 32'd0);
    // backpressure: three bundles against a stalled sink
    wr_ready = 1'b0;
    drive_std(1, 0);
    chk("bp_ready0", 32'(in_ready), 32'd1);
    step();
    drive_std(1, 1);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    step();
    chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_addr", 32'(wr_addr), 32'd36);
    chk("bp_data", wr_data, val(1, 0, 0));
    drive_std(1, 2);
    step();
    step();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(wr_valid), 32'd1);
    chk("bp_hold_addr", 32'(wr_addr), 32'd36);
    chk("bp_hold_data", wr_data, val(1, 0, 0));
    wr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("bp_drain_valid", 32'(wr_valid), 32'd1);
      chk("bp_drain_addr", 32'(wr_addr), 32'(36 + i));
      chk("bp_drain_data", wr_data, val(1, i / 4, i % 4));
      p = in_valid && in_ready;
      step();
      if (p) in_valid = 1'b0;
    end
    chk("bp_idle", 32'(wr_valid), 32'd0);
    // full stream of 288 bundles with a bursty sink
    k = 0; idx = 0; dones = 0; settle = 0; last1151 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wr_ready = (cyc % 5) != 2;
      if (done) begin
        dones++;
        chk("done_after_last", 32'(last1151), 32'd1);
      end
      last1151 = wr_valid && wr_ready && wr_addr == 11'd1151;
      if (wr_valid && wr_ready) begin
        if (wr_addr != 11'(k)) chk("stream_addr", 32'(wr_addr), 32'(k));
        if (wr_data != val(k / 36, (k % 36) / 4, k % 4)) chk("stream_data", wr_data, val(k / 36, (k % 36) / 4, k % 4));
        k++;
      end
      if (idx < 288) drive_std(idx / 9, idx % 9);
      else in_valid = 1'b0;
      p = in_valid && in_ready;
      step();
      if (p) idx++;
      if (k == 1152) settle++;
      if (settle == 3) break;
    end
    chk("stream_words", 32'(k), 32'd1152);
    chk("stream_dones", 32'(dones), 32'd1);
    chk("stream_idle", 32'(wr_valid), 32'd0);
    // reset in the middle of a bundle
    wr_ready = 1'b1;
    drive_std(3, 1);
    step();
    drive_std(3, 2);
    step();
    in_valid = 1'b0;
    step();
    chk("mid_addr_lane2", 32'(wr_addr), 32'd114);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(wr_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_data", wr_data, 32'd0);
    #2 rst_b = 1'b1;
    step();
    drive_std(4, 2);
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(wr_valid), 32'd1);
    chk("post_rst_addr", 32'(wr_addr), 32'd152);
    chk("post_rst_data", wr_data, val(4, 2, 0));
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_idle", 32'(wr_valid), 32'd0);
    // push and pop on the same edge
    drive_std(5, 0);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("pp_lane3_addr", 32'(wr_addr), 32'd183);
    drive_std(5, 1);
    chk("pp_ready_before", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("pp_next_valid", 32'(wr_valid), 32'd1);
    chk("pp_next_addr", 32'(wr_addr), 32'd184);
    chk("pp_next_data", wr_data, val(5, 1, 0));
    chk("pp_ready_after", 32'(in_ready), 32'd1);
    step(); step(); step();
    chk("pp_last_addr", 32'(wr_addr), 32'd187);
    step();
    chk("pp_idle", 32'(wr_valid), 32'd0);
    chk("pp_done", 32'(done), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
